// File: rtl/rf_writeback_if.sv
// Bundle of every handshake and register-file signal of the writeback block.
//
// Handshake rule for both result channels: the producer raises *_valid with
// stable *_rd/*_data and holds them until the cycle in which *_ready is also
// high. The transfer happens on that rising edge. Ready may depend on state
// and rst, but never on the matching valid.
interface rf_writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ALU_DEPTH  = 2
);
  localparam int CNT_WIDTH = $clog2(ALU_DEPTH) + 1;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_busW;

  logic [ADDR_WIDTH-1:0] q_rs1;
  logic [ADDR_WIDTH-1:0] q_rs2;
  logic                  q_hit1;
  logic                  q_hit2;
  logic [DATA_WIDTH-1:0] q_data1;
  logic [DATA_WIDTH-1:0] q_data2;

  // Occupancy of the ALU FIFO, exported for observation.
  logic [CNT_WIDTH-1:0]  alu_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output q_rs1, q_rs2,
    input  alu_ready, lsu_ready,
    input  rf_wen, rf_rd, rf_busW,
    input  q_hit1, q_hit2, q_data1, q_data2,
    input  alu_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  q_rs1, q_rs2,
    output alu_ready, lsu_ready,
    output rf_wen, rf_rd, rf_busW,
    output q_hit1, q_hit2, q_data1, q_data2,
    output alu_count
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: a small FIFO buffers ALU results, LSU
// results bypass it with priority, and one registered write leaves per cycle.
// A combinational bypass lets decode see the value being written this cycle.
module rf_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ALU_DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  rf_writeback_if.slave bus
);
  localparam int PTR_W = $clog2(ALU_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ALU_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_rd   [ALU_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [ALU_DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic full, empty, lsu_win, enq, deq;

  // Readies depend only on occupancy and reset; a full FIFO blocks both
  // sources for one cycle so the head is guaranteed to drain.
  assign bus.alu_ready = !full && !rst;
  assign bus.lsu_ready = !full && !rst;

  // Arbitration, FIFO pointer/count update and next output-stage contents.
  always_comb begin
    full    = (count_q == CNT_FULL);
    empty   = (count_q == '0);
    lsu_win = bus.lsu_valid && !full;
    deq     = !lsu_win && !empty;
    // Writes to x0 are dropped at the door and never occupy a slot.
    enq     = bus.alu_valid && !full && (bus.alu_rd != '0);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wen_d   = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;

    if (lsu_win) begin
      wen_d  = (bus.lsu_rd != '0);
      rd_d   = bus.lsu_rd;
      data_d = bus.lsu_data;
    end else if (deq) begin
      wen_d  = 1'b1;
      rd_d   = fifo_rd[head_q];
      data_d = fifo_data[head_q];
    end

    if (deq) head_d = head_q + PTR_ONE;
    if (enq) tail_d = tail_q + PTR_ONE;

    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state and output stage; reset drops any queued results.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // FIFO storage; contents are meaningless outside the head..tail window.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      fifo_rd[tail_q]   <= bus.alu_rd;
      fifo_data[tail_q] <= bus.alu_data;
    end
  end

  assign bus.rf_wen    = wen_q;
  assign bus.rf_rd     = rd_q;
  assign bus.rf_busW   = data_q;
  assign bus.alu_count = count_q;

  // Same-cycle bypass of the write in flight; x0 never hits.
  always_comb begin
    bus.q_hit1  = wen_q && (rd_q == bus.q_rs1) && (bus.q_rs1 != '0);
    bus.q_hit2  = wen_q && (rd_q == bus.q_rs2) && (bus.q_rs2 != '0);
    bus.q_data1 = bus.q_hit1 ? data_q : '0;
    bus.q_data2 = bus.q_hit2 ? data_q : '0;
  end
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios followed by random traffic,
// checked each cycle against a queue-based model of the writeback rules.
module tb_rf_writeback;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int W     = AW + DW;

  logic clk;
  logic rst;

  rf_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALU_DEPTH(DEPTH)) bus ();

  rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALU_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]  exp_q[$];   // writes expected on rf_* in the current cycle
  logic [W-1:0]  m_q[$];     // ALU results waiting, oldest first
  logic          m_wen  = 1'b0;
  logic [AW-1:0] m_rd   = '0;
  logic [DW-1:0] m_data = '0;
  logic          alu_acc = 1'b0;
  logic          lsu_acc = 1'b0;
  logic          mon_on  = 1'b0;

  int checks = 0;
  int errors = 0;

  initial begin
    logic [W-1:0] e;
    logic full;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_wen = 1'b0; m_rd = '0; m_data = '0;
        alu_acc = 1'b0; lsu_acc = 1'b0;
      end else begin
        full    = (m_q.size() == DEPTH);
        lsu_acc = bus.lsu_valid && !full;
        alu_acc = bus.alu_valid && !full;
        if (lsu_acc) begin
          m_wen = (bus.lsu_rd != 0); m_rd = bus.lsu_rd; m_data = bus.lsu_data;
        end else if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_wen = 1'b1; m_rd = e[W-1:DW]; m_data = e[DW-1:0];
        end else begin
          m_wen = 1'b0;
        end
        if (alu_acc && bus.alu_rd != 0) m_q.push_back({bus.alu_rd, bus.alu_data});
        if (m_wen) exp_q.push_back({m_rd, m_data});
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    logic hit1, hit2;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_wen", 64'(bus.rf_wen), 64'd1);
        check("rf_write", 64'({bus.rf_rd, bus.rf_busW}), 64'(e));
      end else begin
        check("rf_wen_idle", 64'(bus.rf_wen), 64'd0);
      end
      check("rf_rd", 64'(bus.rf_rd), 64'(m_rd));
      check("rf_busW", 64'(bus.rf_busW), 64'(m_data));
      check("alu_ready", 64'(bus.alu_ready), 64'(!rst && m_q.size() < DEPTH));
      check("lsu_ready", 64'(bus.lsu_ready), 64'(!rst && m_q.size() < DEPTH));
      check("alu_count", 64'(bus.alu_count), 64'(m_q.size()));
      hit1 = m_wen && (m_rd == bus.q_rs1) && (bus.q_rs1 != 0);
      hit2 = m_wen && (m_rd == bus.q_rs2) && (bus.q_rs2 != 0);
      check("q_hit1", 64'(bus.q_hit1), 64'(hit1));
      check("q_hit2", 64'(bus.q_hit2), 64'(hit2));
      check("q_data1", 64'(bus.q_data1), hit1 ? 64'(m_data) : 64'd0);
      check("q_data2", 64'(bus.q_data2), hit2 ? 64'(m_data) : 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int alu_n;
    int lsu_n;
    rst = 1'b1;
    set_alu(1'b1, 5'd1, 32'h11);
    set_lsu(1'b1, 5'd2, 32'h22);
    bus.q_rs1 = '0; bus.q_rs2 = '0;

    // Reset held 3 cycles with both valids high.
    cyc(); mon_on = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    set_alu(1'b0, '0, '0);
    set_lsu(1'b0, '0, '0);
    cyc();

    // Single LSU result with bypass probe.
    set_lsu(1'b1, 5'd7, 32'hDEADBEEF);
    bus.q_rs1 = 5'd7; bus.q_rs2 = 5'd3;
    cyc();
    set_lsu(1'b0, '0, '0);
    cyc(); cyc();

    // Two back-to-back ALU results, FIFO order and two-cycle latency.
    bus.q_rs1 = 5'd3; bus.q_rs2 = 5'd4;
    set_alu(1'b1, 5'd3, 32'd1);
    cyc();
    set_alu(1'b1, 5'd4, 32'd2);
    cyc();
    set_alu(1'b0, '0, '0);
    repeat (4) cyc();

    // Contention: continuous LSU stream while x5/x6 enter the FIFO.
    alu_n = 0; lsu_n = 0;
    bus.q_rs1 = 5'd5; bus.q_rs2 = 5'd6;
    set_alu(1'b1, 5'd5, 32'hA);
    set_lsu(1'b1, 5'd10, 32'h100);
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (alu_acc) begin
        alu_n++;
        if (alu_n == 1) set_alu(1'b1, 5'd6, 32'hB);
        else set_alu(1'b0, '0, '0);
      end
      if (lsu_acc) begin
        lsu_n++;
        if (lsu_n < 6) set_lsu(1'b1, AW'(10 + lsu_n), DW'(32'h100 + lsu_n));
        else set_lsu(1'b0, '0, '0);
      end
    end
    repeat (3) cyc();

    // x0 handling on both paths.
    bus.q_rs1 = 5'd0; bus.q_rs2 = 5'd0;
    set_alu(1'b1, 5'd0, 32'h55);
    cyc();
    set_alu(1'b0, '0, '0);
    set_lsu(1'b1, 5'd0, 32'h66);
    cyc();
    set_lsu(1'b0, '0, '0);
    repeat (3) cyc();

    // Mid-run reset with two ALU entries queued behind LSU traffic.
    set_lsu(1'b1, 5'd12, 32'h1200);
    set_alu(1'b1, 5'd8, 32'h800);
    cyc();
    set_lsu(1'b1, 5'd13, 32'h1300);
    set_alu(1'b1, 5'd9, 32'h900);
    cyc();
    rst = 1'b1;
    set_alu(1'b0, '0, '0);
    set_lsu(1'b0, '0, '0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    set_alu(1'b1, 5'd14, 32'h1400);
    cyc();
    set_alu(1'b0, '0, '0);
    repeat (3) cyc();

    // Random traffic, producers hold offers until accepted.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!bus.alu_valid || alu_acc)
        set_alu($urandom_range(0, 99) < 60, AW'($urandom_range(0, 31)), DW'($urandom));
      if (!bus.lsu_valid || lsu_acc)
        set_lsu($urandom_range(0, 99) < 45, AW'($urandom_range(0, 31)), DW'($urandom));
      bus.q_rs1 = $urandom_range(0, 1) ? m_rd : AW'($urandom_range(0, 31));
      bus.q_rs2 = $urandom_range(0, 1) ? bus.lsu_rd : AW'($urandom_range(0, 31));
      cyc();
    end
    rst = 1'b0;
    set_alu(1'b0, '0, '0);
    set_lsu(1'b0, '0, '0);

    // Bounded drain: everything offered must have been written.
    for (int i = 0; i < 50 && (m_q.size() > 0 || exp_q.size() > 0); i++) cyc();
    check("drain", 64'(m_q.size() + exp_q.size()), 64'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
